// File: rtl/vs_fp_add_sub_if.sv
// Operand/result bundle for the registered fixed-point adder/subtractor.
// Flow control is valid-only: in_valid qualifies a/b for one cycle, out_valid is
// high exactly the cycle after an accepted pair, and there is no ready, so the
// sink must always accept.
interface vs_fp_add_sub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] add_result;
    logic [WIDTH-1:0] sub_result;
    logic             add_ovf;
    logic             sub_ovf;

    modport master (
        output in_valid, a, b,
        input  out_valid, add_result, sub_result, add_ovf, sub_ovf
    );

    modport slave (
        input  in_valid, a, b,
        output out_valid, add_result, sub_result, add_ovf, sub_ovf
    );
endinterface

// File: rtl/vs_fp_add_sub.sv
// Registered signed fixed-point adder/subtractor: one pair in, a+b and a-b out
// one cycle later, with per-result overflow flags and optional saturation.
module vs_fp_add_sub #(
    parameter int Q        = 15,
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0
) (
    input logic           clk,
    input logic           rst_n,
    vs_fp_add_sub_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Q only positions the binary point; the arithmetic never depends on it.
    if (Q < 0 || Q >= WIDTH) begin : g_bad_q
        $error("vs_fp_add_sub: Q must satisfy 0 <= Q < WIDTH");
    end

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic             add_ovf_c;
    logic             sub_ovf_c;
    logic [WIDTH-1:0] add_next;
    logic [WIDTH-1:0] sub_next;

    logic             out_valid_q;
    logic [WIDTH-1:0] add_result_q;
    logic [WIDTH-1:0] sub_result_q;
    logic             add_ovf_q;
    logic             sub_ovf_q;

    always_comb begin
        sum_ext  = {bus.a[WIDTH-1], bus.a} + {bus.b[WIDTH-1], bus.b};
        diff_ext = {bus.a[WIDTH-1], bus.a} - {bus.b[WIDTH-1], bus.b};
        // With one guard bit the exact result always fits; overflow means the
        // guard bit and the WIDTH-bit sign disagree, and the guard bit is the
        // true sign, so it also gives the clamp direction.
        add_ovf_c = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
        sub_ovf_c = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
    end

    if (SATURATE != 0) begin : g_sat
        always_comb begin
            add_next = sum_ext[WIDTH-1:0];
            sub_next = diff_ext[WIDTH-1:0];
            if (add_ovf_c) begin
                add_next = sum_ext[WIDTH] ? MIN_NEG : MAX_POS;
            end
            if (sub_ovf_c) begin
                sub_next = diff_ext[WIDTH] ? MIN_NEG : MAX_POS;
            end
        end
    end else begin : g_wrap
        assign add_next = sum_ext[WIDTH-1:0];
        assign sub_next = diff_ext[WIDTH-1:0];
    end

    // Results and flags hold through idle cycles; only out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            add_result_q <= '0;
            sub_result_q <= '0;
            add_ovf_q    <= 1'b0;
            sub_ovf_q    <= 1'b0;
        end else begin
            out_valid_q <= bus.in_valid;
            if (bus.in_valid) begin
                add_result_q <= add_next;
                sub_result_q <= sub_next;
                add_ovf_q    <= add_ovf_c;
                sub_ovf_q    <= sub_ovf_c;
            end
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.add_result = add_result_q;
    assign bus.sub_result = sub_result_q;
    assign bus.add_ovf    = add_ovf_q;
    assign bus.sub_ovf    = sub_ovf_q;
endmodule

// File: tb/tb_vs_fp_add_sub.sv
// Bench for vs_fp_add_sub: wrap and saturating instances share one stimulus
// stream; a 64-bit integer reference model supplies every expected value.
module tb_vs_fp_add_sub;
    localparam int W = 32;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] add_w;
        logic [W-1:0] sub_w;
        logic [W-1:0] add_s;
        logic [W-1:0] sub_s;
        logic         aovf;
        logic         sovf;
    } vec_t;

    // packed result view: {out_valid, add_result, sub_result, add_ovf, sub_ovf}
    localparam int RW = 2 * W + 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [RW-1:0] exp_q0[$];
    logic [RW-1:0] exp_q1[$];

    logic         m_valid;
    logic [W-1:0] m_add[2];
    logic [W-1:0] m_sub[2];
    logic         m_aovf[2];
    logic         m_sovf[2];

    vec_t vecs[8];

    vs_fp_add_sub_if #(.WIDTH(W)) bus_wrap ();
    vs_fp_add_sub_if #(.WIDTH(W)) bus_sat ();

    assign bus_sat.in_valid = bus_wrap.in_valid;
    assign bus_sat.a        = bus_wrap.a;
    assign bus_sat.b        = bus_wrap.b;

    vs_fp_add_sub #(.Q(15), .WIDTH(W), .SATURATE(0)) dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_wrap.slave)
    );

    vs_fp_add_sub #(.Q(15), .WIDTH(W), .SATURATE(1)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_sat.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] act_wrap();
        return {bus_wrap.out_valid, bus_wrap.add_result, bus_wrap.sub_result,
                bus_wrap.add_ovf, bus_wrap.sub_ovf};
    endfunction

    function automatic logic [RW-1:0] act_sat();
        return {bus_sat.out_valid, bus_sat.add_result, bus_sat.sub_result,
                bus_sat.add_ovf, bus_sat.sub_ovf};
    endfunction

    task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum/difference, then wrap or clamp to 32 bits.
    task automatic ref_calc(input logic [W-1:0] av, input logic [W-1:0] bv, input bit sat,
                            output logic [W-1:0] add_o, output logic [W-1:0] sub_o,
                            output logic aovf_o, output logic sovf_o);
        longint sa, sb, s, d;
        logic [63:0] su, du;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        s  = sa + sb;
        d  = sa - sb;
        su = s;
        du = d;
        aovf_o = (s > MAXV) || (s < MINV);
        sovf_o = (d > MAXV) || (d < MINV);
        add_o  = su[W-1:0];
        sub_o  = du[W-1:0];
        if (sat) begin
            if (s > MAXV) add_o = 32'h7fff_ffff;
            if (s < MINV) add_o = 32'h8000_0000;
            if (d > MAXV) sub_o = 32'h7fff_ffff;
            if (d < MINV) sub_o = 32'h8000_0000;
        end
    endtask

    task automatic model_clear();
        m_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_add[i]  = '0;
            m_sub[i]  = '0;
            m_aovf[i] = 1'b0;
            m_sovf[i] = 1'b0;
        end
    endtask

    // driver: present one cycle of input, predict, then compare after the edge
    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        bus_wrap.in_valid = v;
        bus_wrap.a        = av;
        bus_wrap.b        = bv;
        m_valid = v;
        if (v) begin
            for (int i = 0; i < 2; i++) begin
                ref_calc(av, bv, bit'(i), m_add[i], m_sub[i], m_aovf[i], m_sovf[i]);
            end
        end
        exp_q0.push_back({m_valid, m_add[0], m_sub[0], m_aovf[0], m_sovf[0]});
        exp_q1.push_back({m_valid, m_add[1], m_sub[1], m_aovf[1], m_sovf[1]});
        @(posedge clk);
        #1;
        check("wrap_model", act_wrap(), exp_q0.pop_front());
        check("sat_model", act_sat(), exp_q1.pop_front());
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] r;
        case ($urandom_range(0, 7))
            0:       r = 32'h7fff_ffff;
            1:       r = 32'h8000_0000;
            2:       r = 32'h0000_0000;
            3:       r = 32'hffff_ffff;
            default: r = $urandom;
        endcase
        return r;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        model_clear();

        vecs[0] = '{32'h0005_0000, 32'h000a_0000, 32'h000f_0000, 32'hfffb_0000,
                    32'h000f_0000, 32'hfffb_0000, 1'b0, 1'b0};
        vecs[1] = '{32'h0005_0000, 32'hfff6_0000, 32'hfffb_0000, 32'h000f_0000,
                    32'hfffb_0000, 32'h000f_0000, 1'b0, 1'b0};
        vecs[2] = '{32'h000a_0000, 32'hfffb_0000, 32'h0005_0000, 32'h000f_0000,
                    32'h0005_0000, 32'h000f_0000, 1'b0, 1'b0};
        vecs[3] = '{32'hfff6_0000, 32'hfffb_0000, 32'hfff1_0000, 32'hfffb_0000,
                    32'hfff1_0000, 32'hfffb_0000, 1'b0, 1'b0};
        vecs[4] = '{32'h7fff_ffff, 32'h0000_0001, 32'h8000_0000, 32'h7fff_fffe,
                    32'h7fff_ffff, 32'h7fff_fffe, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000,
                    32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                    32'h8000_0000, 32'h7fff_ffff, 1'b0, 1'b1};
        vecs[7] = '{32'h1234_5678, 32'h1234_5678, 32'h2468_acf0, 32'h0000_0000,
                    32'h2468_acf0, 32'h0000_0000, 1'b0, 1'b0};

        // reset: operands presented while in reset must be ignored
        rst_n             = 1'b0;
        bus_wrap.in_valid = 1'b1;
        bus_wrap.a        = 32'h1111_1111;
        bus_wrap.b        = 32'h2222_2222;
        repeat (2) @(posedge clk);
        #1;
        check("reset_wrap", act_wrap(), '0);
        check("reset_sat", act_sat(), '0);
        @(negedge clk);
        rst_n             = 1'b1;
        bus_wrap.in_valid = 1'b0;

        // directed table, issued back to back
        for (int i = 0; i < 8; i++) begin
            step(1'b1, vecs[i].a, vecs[i].b);
            check("tbl_wrap", act_wrap(),
                  {1'b1, vecs[i].add_w, vecs[i].sub_w, vecs[i].aovf, vecs[i].sovf});
            check("tbl_sat", act_sat(),
                  {1'b1, vecs[i].add_s, vecs[i].sub_s, vecs[i].aovf, vecs[i].sovf});
        end

        // idle cycle: out_valid drops, results hold the last pair
        step(1'b0, 32'hdead_beef, 32'h0bad_f00d);
        check32("hold_add", bus_wrap.add_result, 32'h2468_acf0);
        check32("hold_sub", bus_wrap.sub_result, 32'h0000_0000);

        // asynchronous reset mid-stream
        step(1'b1, 32'h0123_4567, 32'h0765_4321);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_wrap", act_wrap(), '0);
        check("async_rst_sat", act_sat(), '0);
        bus_wrap.in_valid = 1'b1;
        bus_wrap.a        = 32'h4000_0000;
        bus_wrap.b        = 32'h4000_0000;
        @(posedge clk);
        #1;
        check("rst_ignore_wrap", act_wrap(), '0);
        check("rst_ignore_sat", act_sat(), '0);
        @(negedge clk);
        rst_n             = 1'b1;
        bus_wrap.in_valid = 1'b0;
        model_clear();
        step(1'b0, 32'h0, 32'h0);

        // randomized stream with edge-biased operands
        for (int n = 0; n < 300; n++) begin
            step(($urandom_range(0, 3) != 0), pick_operand(), pick_operand());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
